// File: rtl/mult_pkg.sv
// Shared types for the Booth multiplier back end.
package mult_pkg;

  localparam int unsigned MULT_A_DW = 8;
  localparam int unsigned MULT_B_DW = 8;
  localparam int unsigned MULT_C_DW = MULT_A_DW + MULT_B_DW;

  // Accumulator sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } pp_accum_state_e;

  // Redundant (carry-save) accumulator value; carry is held pre-shifted.
  typedef struct packed {
    logic [MULT_C_DW-1:0] sum;
    logic [MULT_C_DW-1:0] carry;
  } csa_t;

endpackage

// File: rtl/pp_accum_csa.sv
// 3:2 carry-save compressor; carry output is already aligned one bit up.
module csa #(
  parameter int unsigned DW = 16
) (
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] y,
  input  logic [DW-1:0] z,
  output logic [DW-1:0] s,
  output logic [DW-1:0] c
);

  logic [DW-1:0] maj;

  // Bitwise sum and majority; the shifted-out MSB of the carry is dropped.
  always_comb begin
    s   = x ^ y ^ z;
    maj = (x & y) | (x & z) | (y & z);
    c   = {maj[DW-2:0], 1'b0};
  end

endmodule

// File: rtl/pp_accum.sv
// Sequential Booth partial-product accumulator: one CSA step per cycle, final CPA on the last step.
module pp_accum
  import mult_pkg::*;
#(
  parameter  int unsigned A_DW   = MULT_A_DW,
  parameter  int unsigned B_DW   = MULT_B_DW,
  localparam int unsigned C_DW   = A_DW + B_DW,
  localparam int unsigned HALF   = ((A_DW < B_DW) ? A_DW : B_DW) / 2,
  localparam int unsigned PP_NUM = HALF + 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [HALF:0][C_DW-1:0]    pp_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [C_DW-1:0]            prod_o,
  output logic                       busy_o
);

  localparam int unsigned IDX_W = $clog2(PP_NUM + 1);

  pp_accum_state_e           state_q, state_d;
  logic [HALF:0][C_DW-1:0]   pp_q, pp_d;
  csa_t                      acc_q, acc_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [C_DW-1:0]           prod_q, prod_d;
  logic                      valid_q, valid_d;
  logic                      busy_q, busy_d;

  logic                      accept;
  logic [C_DW-1:0]           csa_s;
  logic [C_DW-1:0]           csa_c;

  // Fold the currently selected partial product into the redundant accumulator.
  csa #(.DW(C_DW)) u_csa (
    .x (acc_q.sum),
    .y (acc_q.carry),
    .z (pp_q[idx_q]),
    .s (csa_s),
    .c (csa_c)
  );

  // Input side may load while idle, or in DONE when the result is drained the same cycle.
  always_comb begin
    ready_o = (state_q == IDLE) | ((state_q == DONE) & ready_i);
    accept  = valid_i & ready_o;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    pp_d    = pp_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    prod_d  = prod_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          pp_d    = pp_i;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d.sum   = csa_s;
        acc_d.carry = csa_c;
        if (idx_q == IDX_W'(PP_NUM - 1)) begin
          prod_d  = csa_s + csa_c;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (ready_i) begin
          if (valid_i) begin
            pp_d    = pp_i;
            acc_d   = '0;
            idx_d   = '0;
            state_d = ACC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    valid_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pp_q    <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      prod_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pp_q    <= pp_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      prod_q  <= prod_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // Registered outputs.
  always_comb begin
    valid_o = valid_q;
    prod_o  = prod_q;
    busy_o  = busy_q;
  end

endmodule

// File: tb/tb_pp_accum.sv
// Self-checking bench for pp_accum (A_DW=B_DW=8).
module tb_pp_accum;

  logic             clk_i;
  logic             rst_i;
  logic             valid_i;
  logic             ready_o;
  logic [4:0][15:0] pp_i;
  logic             valid_o;
  logic             ready_i;
  logic [15:0]      prod_o;
  logic             busy_o;

  int n_checks;
  int n_fail;

  pp_accum dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .pp_i    (pp_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .prod_o  (prod_o),
    .busy_o  (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Radix-4 Booth codec model: four digit rows, negation via ~x with the +1s gathered in row 4.
  function automatic logic [4:0][15:0] make_pp(input logic [7:0] a, input logic [7:0] b);
    logic [4:0][15:0] pp;
    logic [8:0]       bx;
    logic [15:0]      mag;
    logic [15:0]      corr;
    int               d;
    int               m;
    pp   = '0;
    corr = '0;
    bx   = {b, 1'b0};
    for (int k = 0; k < 4; k++) begin
      d = -2 * int'(bx[2*k+2]) + int'(bx[2*k+1]) + int'(bx[2*k]);
      m = int'($signed(a)) * ((d < 0) ? -d : d);
      mag = 16'(m);
      if (d < 0) begin
        pp[k] = (~mag) << (2 * k);
        corr  = corr + (16'd1 << (2 * k));
      end else begin
        pp[k] = mag << (2 * k);
      end
    end
    pp[4] = corr;
    return pp;
  endfunction

  function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
    return 16'(int'($signed(a)) * int'($signed(b)));
  endfunction

  // Present an operand pair and hold valid_i until it is accepted; leaves us just after the accept edge.
  task automatic offer(input logic [7:0] a, input logic [7:0] b, output bit ok);
    ok      = 1'b0;
    pp_i    = make_pp(a, b);
    valid_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (ready_o) begin
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        ok      = 1'b1;
        break;
      end
      @(posedge clk_i); #1;
    end
    valid_i = 1'b0;
  endtask

  // Issue one op, check latency and result; returns positioned in DONE with valid_o high.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input string name);
    logic [15:0] exp;
    bit          ok;
    int          e;
    exp = ref_prod(a, b);
    offer(a, b, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_accept: ready_o never high, expected acceptance", name);
      return;
    end
    e = 0;
    while (!valid_o && e < 20) begin
      @(posedge clk_i); #1;
      e++;
    end
    n_checks++;
    if (e !== 5) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d cycles, expected 5", name, e);
    end
    n_checks++;
    if (prod_o !== exp) begin
      n_fail++;
      $display("FAIL %s_prod: got %h, expected %h", name, prod_o, exp);
    end
  endtask

  task automatic test_reset();
    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    pp_i    = '0;
    repeat (3) @(posedge clk_i);
    #1;
    n_checks++;
    if ({valid_o, busy_o, ready_o, prod_o} !== {1'b0, 1'b0, 1'b1, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b b=%b r=%b p=%h, expected v=0 b=0 r=1 p=0000",
               valid_o, busy_o, ready_o, prod_o);
    end
    rst_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_directed();
    ready_i = 1'b1;
    run_op(8'd3,   8'd5,   "p3x5");
    @(posedge clk_i); #1;
    run_op(8'h80,  8'h80,  "m128xm128");
    @(posedge clk_i); #1;
    run_op(8'd127, 8'h80,  "p127xm128");
    @(posedge clk_i); #1;
    run_op(8'hFF,  8'd1,   "m1x1");
    @(posedge clk_i); #1;
    n_checks++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_idle: got v=%b b=%b, expected 0 0", valid_o, busy_o);
    end
  endtask

  task automatic test_stall();
    logic [15:0] held;
    ready_i = 1'b0;
    run_op(8'd45, 8'hE7, "stall");
    held    = ref_prod(8'd45, 8'hE7);
    pp_i    = make_pp(8'd9, 8'd9);
    valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_checks++;
      if (ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_ready_o: cycle %0d got %b, expected 0", i, ready_o);
      end
      @(posedge clk_i); #1;
      n_checks++;
      if (valid_o !== 1'b1 || prod_o !== held || busy_o !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold: cycle %0d got v=%b p=%h b=%b, expected v=1 p=%h b=1",
                 i, valid_o, prod_o, busy_o, held);
      end
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    #1;
    n_checks++;
    if (ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release_ready: got %b, expected 1", ready_o);
    end
    @(posedge clk_i); #1;
    n_checks++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0 || prod_o !== held) begin
      n_fail++;
      $display("FAIL stall_drain: got v=%b b=%b p=%h, expected v=0 b=0 p=%h",
               valid_o, busy_o, prod_o, held);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp2;
    int          e;
    ready_i = 1'b1;
    run_op(8'h9C, 8'd77, "b2b_first");
    exp2    = ref_prod(8'd113, 8'hC5);
    pp_i    = make_pp(8'd113, 8'hC5);
    valid_i = 1'b1;
    #1;
    n_checks++;
    if (ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready_o: got %b, expected 1", ready_o);
    end
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    n_checks++;
    if (valid_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_reload: got v=%b b=%b, expected v=0 b=1", valid_o, busy_o);
    end
    e = 0;
    while (!valid_o && e < 20) begin
      @(posedge clk_i); #1;
      e++;
    end
    n_checks++;
    if (e !== 5) begin
      n_fail++;
      $display("FAIL b2b_latency: got %0d cycles, expected 5", e);
    end
    n_checks++;
    if (prod_o !== exp2) begin
      n_fail++;
      $display("FAIL b2b_prod: got %h, expected %h", prod_o, exp2);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_mid_reset();
    bit ok;
    ready_i = 1'b1;
    offer(8'd100, 8'd50, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL midrst_accept: ready_o never high, expected acceptance");
    end
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    #1;
    n_checks++;
    if ({valid_o, busy_o, ready_o, prod_o} !== {1'b0, 1'b0, 1'b1, 16'h0000}) begin
      n_fail++;
      $display("FAIL midrst_async: got v=%b b=%b r=%b p=%h, expected v=0 b=0 r=1 p=0000",
               valid_o, busy_o, ready_o, prod_o);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    #1;
    n_checks++;
    if ({valid_o, busy_o, ready_o, prod_o} !== {1'b0, 1'b0, 1'b1, 16'h0000}) begin
      n_fail++;
      $display("FAIL midrst_next: got v=%b b=%b r=%b p=%h, expected v=0 b=0 r=1 p=0000",
               valid_o, busy_o, ready_o, prod_o);
    end
    @(posedge clk_i); #1;
    run_op(8'd7, 8'hFD, "p7xm3");
    n_checks++;
    if (prod_o !== 16'hFFEB) begin
      n_fail++;
      $display("FAIL p7xm3_const: got %h, expected FFEB", prod_o);
    end
    @(posedge clk_i); #1;
  endtask

  // Random traffic with gaps and downstream stalls, scored against plain signed multiplication.
  task automatic test_random();
    localparam int N_OPS = 4000;
    logic [15:0] exp_q[$];
    logic [15:0] cur_exp;
    logic [15:0] want;
    logic [7:0]  a;
    logic [7:0]  b;
    int          sent;
    int          got;
    int          cyc;
    bit          fire_in;
    bit          fire_out;
    sent    = 0;
    got     = 0;
    cyc     = 0;
    cur_exp = '0;
    valid_i = 1'b0;
    while (got < N_OPS && cyc < 80000) begin
      if (!valid_i && sent < N_OPS && $urandom_range(0, 3) != 0) begin
        a       = 8'($urandom);
        b       = 8'($urandom);
        pp_i    = make_pp(a, b);
        cur_exp = ref_prod(a, b);
        valid_i = 1'b1;
      end
      ready_i = ($urandom_range(0, 2) != 0);
      #1;
      fire_in  = valid_i & ready_o;
      fire_out = valid_o & ready_i;
      if (fire_out) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_spurious: got result %h, expected none pending", prod_o);
        end else begin
          want = exp_q.pop_front();
          if (prod_o !== want) begin
            n_fail++;
            $display("FAIL rand_prod: op %0d got %h, expected %h", got, prod_o, want);
          end
        end
        got++;
      end
      if (fire_in) begin
        exp_q.push_back(cur_exp);
        sent++;
      end
      @(posedge clk_i); #1;
      cyc++;
      if (fire_in) valid_i = 1'b0;
    end
    valid_i = 1'b0;
    n_checks++;
    if (got !== N_OPS) begin
      n_fail++;
      $display("FAIL rand_timeout: got %0d results, expected %0d", got, N_OPS);
    end
  endtask

  initial begin
    #4ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_directed();
    test_stall();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
